sample_delay_line: RTL and testbench

//   Programmable N-sample delay line for ADC channel data. Generalises the
//   one-sample latch delayer to a circular buffer with a runtime-selected delay.

---
 rtl/sample_delay_line_if.sv | 24 ++
 rtl/sample_delay_line.sv | 93 +++++++++
 tb/tb_sample_delay_line.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sample_delay_line_if.sv
// Sample-stream bus between the sample source and the programmable delay line.
// The master drives the sample and its controls; the slave returns the delayed output.
interface sample_delay_line_if #(
    parameter int WIDTH      = 14,
    parameter int DEPTH_LOG2 = 8
);
    logic                    sample_strobe;
    logic signed [WIDTH-1:0] din;
    logic [DEPTH_LOG2-1:0]   delay;
    logic [1:0]              mode;
    logic signed [WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    primed;

    modport master (
        output sample_strobe, din, delay, mode,
        input  dout, dout_valid, primed
    );

    modport slave (
        input  sample_strobe, din, delay, mode,
        output dout, dout_valid, primed
    );
endinterface

// File: rtl/sample_delay_line.sv
// Programmable N-sample delay line over a circular buffer.
// Modes: bypass, delay, echo (dry + half-scale delayed, saturated) and freeze.
module sample_delay_line #(
    parameter int WIDTH      = 14,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    sample_delay_line_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DELAY  = 2'b01,
        MODE_ECHO   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_e;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wp;
    logic [DEPTH_LOG2-1:0]   fill;
    logic [DEPTH_LOG2-1:0]   rp;
    logic                    history_ok;
    logic signed [WIDTH-1:0] delayed;
    logic signed [WIDTH:0]   echo_wide;
    logic signed [WIDTH-1:0] echo_sat;
    logic signed [WIDTH-1:0] dout_next;
    mode_e                   mode;

    assign mode = mode_e'(bus.mode);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rp         = wp - bus.delay;
        history_ok = (bus.delay == '0) || (fill >= bus.delay);
        delayed    = '0;
        echo_wide  = '0;
        echo_sat   = '0;
        dout_next  = '0;

        // delay==0 takes din directly, so the RAM is never read at the address being written.
        if (bus.delay == '0)
            delayed = bus.din;
        else if (history_ok)
            delayed = mem[rp];

        echo_wide = (WIDTH+1)'(bus.din) + (WIDTH+1)'(delayed >>> 1);
        if (echo_wide[WIDTH] != echo_wide[WIDTH-1])
            echo_sat = echo_wide[WIDTH] ? SAT_MIN : SAT_MAX;
        else
            echo_sat = echo_wide[WIDTH-1:0];

        unique case (mode)
            MODE_BYPASS: dout_next = bus.din;
            MODE_DELAY:  dout_next = delayed;
            MODE_ECHO:   dout_next = echo_sat;
            MODE_FREEZE: dout_next = bus.dout;
        endcase
    end

    // NOTE: the sample RAM has no reset; stale entries are hidden by the fill count instead.
    always_ff @(posedge clk_in) begin
        if (!reset && bus.sample_strobe && mode != MODE_FREEZE)
            mem[wp] <= bus.din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wp             <= '0;
            fill           <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.primed     <= 1'b0;
        end else begin
            bus.dout_valid <= bus.sample_strobe;
            if (bus.sample_strobe) begin
                bus.primed <= history_ok;
                bus.dout   <= dout_next;
                if (mode != MODE_FREEZE) begin
                    wp   <= wp + PTR_ONE;
                    fill <= (fill == FILL_MAX) ? fill : fill + PTR_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_sample_delay_line.sv
// Directed bench for sample_delay_line (DEPTH_LOG2=4) with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_sample_delay_line;
    localparam int WIDTH      = 14;
    localparam int DEPTH_LOG2 = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    sample_delay_line_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    sample_delay_line #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; one strobe with din=d, then check the registered result.
    // With gap=0 the next call keeps the strobe high (back-to-back strobes).
    task automatic step(input string tag, input int d, input int exp_dout,
                        input int exp_primed, input bit gap);
        bus.sample_strobe = 1'b1;
        bus.din           = WIDTH'(d);
        @(negedge clk);
        bus.sample_strobe = 1'b0;
        check({tag, ".valid"},  {31'b0, bus.dout_valid}, 1);
        check({tag, ".dout"},   $signed(bus.dout), exp_dout);
        check({tag, ".primed"}, {31'b0, bus.primed}, exp_primed);
        if (gap) begin
            @(negedge clk);
            check({tag, ".idle"}, {31'b0, bus.dout_valid}, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset             = 1'b1;
        bus.sample_strobe = 1'b0;
        bus.din           = '0;
        bus.delay         = '0;
        bus.mode          = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("reset.dout",   $signed(bus.dout), 0);
        check("reset.valid",  {31'b0, bus.dout_valid}, 0);
        check("reset.primed", {31'b0, bus.primed}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Delay of 3 on a ramp: three zeros, then the ramp; primed with the 4th output.
        bus.mode  = 2'b01;
        bus.delay = 4'd3;
        step("t1.s1", 1, 0, 0, 1);
        step("t1.s2", 2, 0, 0, 1);
        step("t1.s3", 3, 0, 0, 1);
        step("t1.s4", 4, 1, 1, 1);
        step("t1.s5", 5, 2, 1, 1);
        step("t1.s6", 6, 3, 1, 1);

        // Zero delay passes din straight through, always primed; then bypass mode.
        bus.delay = 4'd0;
        step("t2.d0", -5, -5, 1, 1);
        bus.mode = 2'b00;
        step("t2.byp", 7, 7, 1, 1);

        // Maximum delay 15 across several write-pointer wraps, back-to-back strobes.
        do_reset();
        bus.mode  = 2'b01;
        bus.delay = 4'd15;
        for (int n = 1; n <= 40; n++)
            step($sformatf("t3.n%0d", n), 100 + n, (n >= 16) ? (100 + n - 15) : 0,
                 (n >= 16) ? 1 : 0, 1'b0);
        @(negedge clk);
        check("t3.idle", {31'b0, bus.dout_valid}, 0);

        // Echo with saturation at both rails.
        do_reset();
        bus.mode  = 2'b10;
        bus.delay = 4'd1;
        step("t4.p1", 8191, 8191, 0, 1);
        step("t4.p2", 8191, 8191, 1, 1);
        step("t4.n1", -8192, -4097, 1, 1);
        step("t4.n2", -8192, -8192, 1, 1);
        step("t4.mid", 100, -3996, 1, 1);

        // Freeze holds dout and history while still pulsing valid.
        do_reset();
        bus.mode  = 2'b01;
        bus.delay = 4'd1;
        step("t5.a", 10, 0, 0, 1);
        step("t5.b", 20, 10, 1, 1);
        step("t5.c", 30, 20, 1, 1);
        bus.mode = 2'b11;
        for (int k = 0; k < 5; k++)
            step($sformatf("t5.frz%0d", k), 40 + k, 20, 1, (k == 4));
        bus.mode = 2'b01;
        step("t5.r1", 50, 30, 1, 1);
        step("t5.r2", 60, 50, 1, 1);

        // Reset coinciding with a strobe discards all history.
        bus.delay = 4'd2;
        step("t6.pre", 70, 50, 1, 1);
        reset             = 1'b1;
        bus.sample_strobe = 1'b1;
        bus.din           = WIDTH'(999);
        @(negedge clk);
        bus.sample_strobe = 1'b0;
        reset             = 1'b0;
        check("t6.rst.dout",   $signed(bus.dout), 0);
        check("t6.rst.valid",  {31'b0, bus.dout_valid}, 0);
        check("t6.rst.primed", {31'b0, bus.primed}, 0);
        @(negedge clk);
        check("t6.rst.idle", {31'b0, bus.dout_valid}, 0);
        step("t6.s1", 201, 0, 0, 1);
        step("t6.s2", 202, 0, 0, 1);
        step("t6.s3", 203, 201, 1, 1);
        step("t6.s4", 204, 202, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
